// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: latches operands and decoded fields for EX, detects
// load-use hazards (bubble insert + ID hold), holds on EX stall while refreshing
// operands from writeback, and clears the control fields on flush.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_in,
    input  logic [XLEN-1:0]   id_pc_in,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [1:0]        id_rs_use,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_is_load,
    input  logic              id_reg_write,
    input  logic              wb_valid_in,
    input  logic [4:0]        wb_addr_in,
    input  logic [XLEN-1:0]   wb_data_in,
    input  logic              ex_stall_in,
    input  logic              flush_in,
    output logic              ex_valid_out,
    output logic [XLEN-1:0]   ex_pc_out,
    output logic [4:0]        ex_rd_addr_out,
    output logic [XLEN-1:0]   ex_rs1_data_out,
    output logic [XLEN-1:0]   ex_rs2_data_out,
    output logic [XLEN-1:0]   ex_imm_out,
    output logic [CTRL_W-1:0] ex_ctrl_out,
    output logic              ex_is_load_out,
    output logic              ex_reg_write_out,
    output logic              id_stall_out,
    output logic              load_use_hazard,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rs1_addr_q, rs1_addr_d;
    logic [4:0]        rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              is_load_q, is_load_d;
    logic              reg_write_q, reg_write_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    // Load-use detect against the load currently held in EX, and the ID hold request.
    always_comb begin
        hazard = id_valid_in & valid_q & is_load_q & (rd_q != 5'd0) &
                 ((id_rs_use[0] & (rd_q == id_rs1_addr)) |
                  (id_rs_use[1] & (rd_q == id_rs2_addr)));
        id_stall_out    = ~flush_in & (ex_stall_in | hazard);
        load_use_hazard = hazard;
    end

    // Next-state: flush > stall (with WB refresh) > bubble insert > capture.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        is_load_d   = is_load_q;
        reg_write_d = reg_write_q;
        cnt_d       = cnt_q;
        if (flush_in) begin
            valid_d     = 1'b0;
            ctrl_d      = '0;
            is_load_d   = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = '0;
            state_d     = ST_RUN;
        end else if (ex_stall_in) begin
            if (wb_valid_in && (wb_addr_in != 5'd0)) begin
                if (wb_addr_in == rs1_addr_q) rs1_data_d = wb_data_in;
                if (wb_addr_in == rs2_addr_q) rs2_data_d = wb_data_in;
            end
        end else if (hazard) begin
            valid_d     = 1'b0;
            ctrl_d      = '0;
            is_load_d   = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = '0;
            state_d     = ST_BUBBLE;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
            state_d = ST_RUN;
            if (id_valid_in) begin
                valid_d     = 1'b1;
                pc_d        = id_pc_in;
                rd_d        = id_rd_addr;
                rs1_addr_d  = id_rs1_addr;
                rs2_addr_d  = id_rs2_addr;
                rs1_data_d  = id_rs1_data;
                rs2_data_d  = id_rs2_data;
                imm_d       = id_imm;
                ctrl_d      = id_ctrl;
                is_load_d   = id_is_load;
                reg_write_d = id_reg_write;
            end else begin
                valid_d     = 1'b0;
                ctrl_d      = '0;
                is_load_d   = 1'b0;
                reg_write_d = 1'b0;
                rd_d        = '0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rd_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            is_load_q   <= 1'b0;
            reg_write_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            is_load_q   <= is_load_d;
            reg_write_q <= reg_write_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_valid_out     = valid_q;
    assign ex_pc_out        = pc_q;
    assign ex_rd_addr_out   = rd_q;
    assign ex_rs1_data_out  = rs1_data_q;
    assign ex_rs2_data_out  = rs2_data_q;
    assign ex_imm_out       = imm_q;
    assign ex_ctrl_out      = ctrl_q;
    assign ex_is_load_out   = is_load_q;
    assign ex_reg_write_out = reg_write_q;
    assign bubble_cnt       = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (CNT_W=2 to reach saturation).
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_in;
    logic [31:0] id_pc_in;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [1:0]  id_rs_use;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [15:0] id_ctrl;
    logic        id_is_load, id_reg_write;
    logic        wb_valid_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        ex_stall_in, flush_in;
    logic        ex_valid_out;
    logic [31:0] ex_pc_out;
    logic [4:0]  ex_rd_addr_out;
    logic [31:0] ex_rs1_data_out, ex_rs2_data_out, ex_imm_out;
    logic [15:0] ex_ctrl_out;
    logic        ex_is_load_out, ex_reg_write_out;
    logic        id_stall_out, load_use_hazard;
    logic [1:0]  bubble_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [1:0]  cnt_before;

    id_ex_pipe_reg #(.XLEN(32), .CTRL_W(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid_in(id_valid_in), .id_pc_in(id_pc_in),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs_use(id_rs_use), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_is_load(id_is_load), .id_reg_write(id_reg_write),
        .wb_valid_in(wb_valid_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .ex_stall_in(ex_stall_in), .flush_in(flush_in),
        .ex_valid_out(ex_valid_out), .ex_pc_out(ex_pc_out), .ex_rd_addr_out(ex_rd_addr_out),
        .ex_rs1_data_out(ex_rs1_data_out), .ex_rs2_data_out(ex_rs2_data_out),
        .ex_imm_out(ex_imm_out), .ex_ctrl_out(ex_ctrl_out), .ex_is_load_out(ex_is_load_out),
        .ex_reg_write_out(ex_reg_write_out), .id_stall_out(id_stall_out),
        .load_use_hazard(load_use_hazard), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_in = 0; id_pc_in = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs_use = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_ctrl = '0;
        id_is_load = 0; id_reg_write = 0; wb_valid_in = 0; wb_addr_in = '0; wb_data_in = '0;
        ex_stall_in = 0; flush_in = 0;
    endtask

    // ID holds a load writing rd
    task automatic set_load(input logic [4:0] rd);
        idle_inputs();
        id_valid_in = 1; id_pc_in = 32'h300; id_rd_addr = rd; id_is_load = 1; id_reg_write = 1;
        id_ctrl = 16'h00A5;
    endtask

    // ID holds an add reading rs1
    task automatic set_add(input logic [4:0] rs1, input logic [4:0] rd);
        idle_inputs();
        id_valid_in = 1; id_pc_in = 32'h304; id_rs1_addr = rs1; id_rs2_addr = 5'd9;
        id_rs_use = 2'b01; id_rd_addr = rd; id_reg_write = 1; id_ctrl = 16'h0011;
    endtask

    initial begin
        // 1: reset with random data inputs
        idle_inputs();
        rst = 1;
        id_pc_in = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_ctrl = 16'($urandom); id_rd_addr = 5'($urandom); id_valid_in = 1; id_is_load = 1;
        wb_valid_in = 1; wb_addr_in = 5'($urandom); wb_data_in = $urandom;
        tick(); tick();
        check("rst_valid", ex_valid_out, 0);
        check("rst_pc", ex_pc_out, 0);
        check("rst_rs1", ex_rs1_data_out, 0);
        check("rst_ctrl", ex_ctrl_out, 0);
        check("rst_load", ex_is_load_out, 0);
        check("rst_cnt", bubble_cnt, 0);
        check("rst_stall", id_stall_out, 0);
        rst = 0;
        idle_inputs();

        // 2: simple capture
        id_valid_in = 1; id_pc_in = 32'h100; id_rs1_data = 32'h11; id_rd_addr = 5'd3;
        id_imm = 32'h44; id_reg_write = 1;
        tick();
        check("cap_valid", ex_valid_out, 1);
        check("cap_pc", ex_pc_out, 32'h100);
        check("cap_rs1", ex_rs1_data_out, 32'h11);
        check("cap_rd", ex_rd_addr_out, 3);
        check("cap_imm", ex_imm_out, 32'h44);

        // 3: load-use bubble
        set_load(5'd5);
        tick();
        check("lw_load", ex_is_load_out, 1);
        set_add(5'd5, 5'd6);
        #1;
        check("lu_hazard", load_use_hazard, 1);
        check("lu_stall", id_stall_out, 1);
        tick();
        check("lu_bub_valid", ex_valid_out, 0);
        check("lu_bub_rd", ex_rd_addr_out, 0);
        check("lu_cnt", bubble_cnt, 1);
        check("lu_nohaz", load_use_hazard, 0);
        tick();
        check("lu_add_valid", ex_valid_out, 1);
        check("lu_add_rd", ex_rd_addr_out, 6);
        check("lu_add_ctrl", ex_ctrl_out, 16'h0011);
        // rs1 use bit cleared -> no hazard on rs2 mismatch either
        set_load(5'd5); tick();
        set_add(5'd5, 5'd6); id_rs_use = 2'b10; #1;
        check("lu_unused", load_use_hazard, 0);

        // 4: stall with WB refresh; x0 never refreshed
        idle_inputs();
        id_valid_in = 1; id_pc_in = 32'h200; id_rs1_addr = 5'd0; id_rs1_data = 32'h22;
        id_rs2_addr = 5'd7; id_rs2_data = 32'h0; id_rd_addr = 5'd8; id_reg_write = 1;
        tick();
        idle_inputs();
        id_valid_in = 1; id_pc_in = 32'hFFFF; id_rd_addr = 5'd1;
        ex_stall_in = 1; wb_valid_in = 1; wb_addr_in = 5'd7; wb_data_in = 32'hDEAD;
        #1;
        check("st_idstall", id_stall_out, 1);
        tick();
        check("st_rs2_ref", ex_rs2_data_out, 32'hDEAD);
        check("st_pc_hold", ex_pc_out, 32'h200);
        check("st_rd_hold", ex_rd_addr_out, 8);
        check("st_rs1_hold", ex_rs1_data_out, 32'h22);
        wb_addr_in = 5'd0; wb_data_in = 32'hBEEF;
        tick();
        check("st_x0_rs1", ex_rs1_data_out, 32'h22);
        check("st_x0_rs2", ex_rs2_data_out, 32'hDEAD);

        // 5: flush overrides stall and hazard
        set_load(5'd5); tick();
        cnt_before = bubble_cnt;
        set_add(5'd5, 5'd6); ex_stall_in = 1; flush_in = 1;
        #1;
        check("fl_hazard", load_use_hazard, 1);
        check("fl_idstall", id_stall_out, 0);
        tick();
        check("fl_valid", ex_valid_out, 0);
        check("fl_load", ex_is_load_out, 0);
        check("fl_rd", ex_rd_addr_out, 0);
        check("fl_cnt", bubble_cnt, cnt_before);

        // 6: saturating counter 1,2,3,3,3 after mid-run reset
        idle_inputs(); rst = 1; tick(); rst = 0;
        check("sat_rst", bubble_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            set_load(5'd5); tick();
            set_add(5'd5, 5'd6); tick();
            check($sformatf("sat_cnt%0d", i), bubble_cnt, (i < 3) ? i + 1 : 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
